// File: rtl/mem_bus_pkg.sv
// Shared definitions for the main-memory bus and its two-master arbiter.
//   AW, DW      : word-address and data widths of the main memory
//   mst_e       : master index (M_CPU = CPU, M_LDR = loader/DMA engine)
//   ACC_RD/WR   : access kind carried on a master's we line
package mem_bus_pkg;

  localparam int AW = 30;
  localparam int DW = 32;

  typedef enum logic {
    M_CPU = 1'b0,
    M_LDR = 1'b1
  } mst_e;

  localparam logic ACC_RD = 1'b0;
  localparam logic ACC_WR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick with lock override. Purely combinational.
//   req_i         : [1:0] request per master
//   last_owner_i  : master granted most recently
//   lock_active_i : keep last_owner_i granted (caller guarantees it is requesting)
//   gnt_o         : [1:0] one-hot grant, or zero when nobody requests
module rr_arb2
  import mem_bus_pkg::mst_e, mem_bus_pkg::M_LDR;
(
  input  logic [1:0] req_i,
  input  mst_e       last_owner_i,
  input  logic       lock_active_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (lock_active_i) begin
      gnt_o = (last_owner_i == M_LDR) ? 2'b10 : 2'b01;
    end else begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // Tie: the master that did not own the bus last goes next.
        2'b11:   gnt_o = (last_owner_i == M_LDR) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single synchronous main memory between the CPU (master 0) and
// the loader/DMA engine (master 1). Round-robin with a bounded lock, read
// ownership tracking so each master sees only its own read data, and a
// saturating contention counter.
//   clk, rst                : clock, synchronous active-low reset
//   mN_req/we/lock/addr/wdata : master N request, held until mN_gnt
//   mN_gnt                  : access issued to memory this cycle
//   mN_rvalid/rdata         : read return, one cycle after the read grant
//   mem_re/we/addr/wdata    : memory command (zeroed when nothing is granted)
//   mem_rdata               : registered memory read data
//   stall_cnt               : cycles in which a requester was left waiting
module mem_arbiter
  import mem_bus_pkg::mst_e, mem_bus_pkg::M_CPU, mem_bus_pkg::M_LDR,
         mem_bus_pkg::ACC_WR;
#(
  parameter int AW       = mem_bus_pkg::AW,
  parameter int DW       = mem_bus_pkg::DW,
  parameter int LOCK_MAX = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic             m0_lock,
  input  logic [AW-1:0]    m0_addr,
  input  logic [DW-1:0]    m0_wdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic             m1_lock,
  input  logic [AW-1:0]    m1_addr,
  input  logic [DW-1:0]    m1_wdata,
  output logic             m0_gnt,
  output logic             m1_gnt,
  output logic             m0_rvalid,
  output logic             m1_rvalid,
  output logic [DW-1:0]    m0_rdata,
  output logic [DW-1:0]    m1_rdata,
  output logic             mem_re,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [LW-1:0] LOCK_LIM = LW'(LOCK_MAX);

  mst_e             last_owner_q, last_owner_d;
  logic             prev_lock_q, prev_lock_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             rd_v_q, rd_v_d;
  mst_e             rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0]    arb_gnt;
  logic [1:0]    gnt;
  logic          gnt_any;
  mst_e          gnt_idx;
  logic          own_req;
  logic          oth_req;
  logic          lock_active;
  logic          sel_we;
  logic          sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          stall_ev;

  assign own_req = (last_owner_q == M_CPU) ? m0_req : m1_req;
  assign oth_req = (last_owner_q == M_CPU) ? m1_req : m0_req;

  // A lock only matters while its holder keeps asking and the budget lasts;
  // once exhausted the plain round-robin pick hands the bus over.
  assign lock_active = prev_lock_q && own_req && (lock_cnt_q < LOCK_LIM);

  rr_arb2 u_rr_arb2 (
    .req_i        ({m1_req, m0_req}),
    .last_owner_i (last_owner_q),
    .lock_active_i(lock_active),
    .gnt_o        (arb_gnt)
  );

  // Reset holds the memory side quiet even before the first clock edge.
  assign gnt     = arb_gnt & {2{rst}};
  assign gnt_any = |gnt;
  assign gnt_idx = gnt[1] ? M_LDR : M_CPU;
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];

  always_comb begin
    sel_we    = m0_we;
    sel_lock  = m0_lock;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (gnt[1]) begin
      sel_we    = m1_we;
      sel_lock  = m1_lock;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  assign mem_we    = gnt_any && (sel_we == ACC_WR);
  assign mem_re    = gnt_any && (sel_we != ACC_WR);
  assign mem_addr  = gnt_any ? sel_addr  : '0;
  assign mem_wdata = gnt_any ? sel_wdata : '0;

  assign m0_rvalid = rst && rd_v_q && (rd_owner_q == M_CPU);
  assign m1_rvalid = rst && rd_v_q && (rd_owner_q == M_LDR);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  assign stall_ev  = (m0_req && !gnt[0]) || (m1_req && !gnt[1]);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    last_owner_d = last_owner_q;
    prev_lock_d  = prev_lock_q;
    lock_cnt_d   = '0;
    rd_v_d       = 1'b0;
    rd_owner_d   = rd_owner_q;
    stall_cnt_d  = stall_cnt_q;

    if (gnt_any) begin
      last_owner_d = gnt_idx;
      prev_lock_d  = sel_lock;
      if (gnt_idx == last_owner_q && prev_lock_q) begin
        // Only time spent holding off a waiting master uses up the budget.
        if (!oth_req) begin
          lock_cnt_d = lock_cnt_q;
        end else if (lock_cnt_q < LOCK_LIM) begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end else begin
          lock_cnt_d = LOCK_LIM;
        end
      end
      if (sel_we != ACC_WR) begin
        rd_v_d     = 1'b1;
        rd_owner_d = gnt_idx;
      end
    end

    if (stall_ev && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner_q <= M_LDR;
      prev_lock_q  <= 1'b0;
      lock_cnt_q   <= '0;
      rd_v_q       <= 1'b0;
      rd_owner_q   <= M_CPU;
      stall_cnt_q  <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      prev_lock_q  <= prev_lock_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_v_q       <= rd_v_d;
      rd_owner_q   <= rd_owner_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock;
  logic [29:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m1_req, m1_we, m1_lock;
  logic [29:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_re, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_stall;

  typedef struct {
    bit          mst;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
  endfunction

  // Memory model: one-cycle registered read.
  bit [31:0] mem_arr [256];
  bit        written [256];
  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_re)
      mem_rdata <= written[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  end

  // Stimulus must hold we/addr/wdata while waiting for a grant.
  logic        p_rst, p_req0, p_gnt0, p_we0, p_req1, p_gnt1, p_we1;
  logic [29:0] p_a0, p_a1;
  logic [31:0] p_d0, p_d1;
  initial p_rst = 1'b0;
  always @(posedge clk) begin
    if (p_rst && rst && p_req0 && !p_gnt0 && m0_req)
      assert (m0_we == p_we0 && m0_addr == p_a0 && m0_wdata == p_d0)
        else $error("m0 changed request while waiting");
    if (p_rst && rst && p_req1 && !p_gnt1 && m1_req)
      assert (m1_we == p_we1 && m1_addr == p_a1 && m1_wdata == p_d1)
        else $error("m1 changed request while waiting");
    p_rst <= rst;
    p_req0 <= m0_req; p_gnt0 <= m0_gnt; p_we0 <= m0_we; p_a0 <= m0_addr; p_d0 <= m0_wdata;
    p_req1 <= m1_req; p_gnt1 <= m1_gnt; p_we1 <= m1_we; p_a1 <= m1_addr; p_d1 <= m1_wdata;
  end

  function automatic logic [31:0] exp_data(input logic [29:0] a);
    int k;
    k = int'(a[7:0]);
    return ref_mem.exists(k) ? ref_mem[k] : init_val(a[7:0]);
  endfunction

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    idle_inputs();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_stall = '0;
    sb.delete();
  endtask

  // One bus cycle: check grant/issue now, then the read return and stall
  // count just after the edge.
  task automatic cycle(input bit eg0, input bit eg1);
    exp_t        e;
    logic        we_x;
    logic [29:0] ad_x;
    logic [31:0] wd_x;
    #1;
    total++;
    if (m0_gnt !== eg0 || m1_gnt !== eg1) begin
      bad++;
      $display("FAIL gnt: got m1/m0=%b%b want %b%b at %0t", m1_gnt, m0_gnt, eg1, eg0, $time);
    end
    if (eg0 || eg1) begin
      we_x = eg0 ? m0_we : m1_we;
      ad_x = eg0 ? m0_addr : m1_addr;
      wd_x = eg0 ? m0_wdata : m1_wdata;
      total++;
      if (mem_we !== we_x || mem_re !== !we_x || mem_addr !== ad_x || (we_x && mem_wdata !== wd_x)) begin
        bad++;
        $display("FAIL issue: got re=%b we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                 mem_re, mem_we, mem_addr, mem_wdata, we_x, ad_x, wd_x);
      end
      if (!we_x) begin
        e.mst  = eg1;
        e.data = exp_data(ad_x);
        sb.push_back(e);
      end else begin
        ref_mem[int'(ad_x[7:0])] = wd_x;
      end
    end else begin
      total++;
      if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
        bad++;
        $display("FAIL idle_bus: got re=%b we=%b addr=%h wdata=%h want all 0", mem_re, mem_we, mem_addr, mem_wdata);
      end
    end
    if (((m0_req && !eg0) || (m1_req && !eg1)) && exp_stall != 16'hFFFF) exp_stall++;
    @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.mst == 1'b0) begin
        if (m0_rvalid !== 1'b1 || m0_rdata !== e.data || m1_rvalid !== 1'b0 || m1_rdata !== '0) begin
          bad++;
          $display("FAIL rd_m0: got v0=%b d0=%h v1=%b d1=%h want v0=1 d0=%h v1=0 d1=0",
                   m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, e.data);
        end
      end else begin
        if (m1_rvalid !== 1'b1 || m1_rdata !== e.data || m0_rvalid !== 1'b0 || m0_rdata !== '0) begin
          bad++;
          $display("FAIL rd_m1: got v1=%b d1=%h v0=%b d0=%h want v1=1 d1=%h v0=0 d0=0",
                   m1_rvalid, m1_rdata, m0_rvalid, m0_rdata, e.data);
        end
      end
    end else if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== '0 || m1_rdata !== '0) begin
      bad++;
      $display("FAIL no_rd: got v0=%b v1=%b d0=%h d1=%h want all 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    total++;
    if (stall_cnt !== exp_stall) begin
      bad++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    m0_req = 1; m0_addr = 30'h1; m1_req = 1; m1_addr = 30'h2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (m0_gnt !== 0 || m1_gnt !== 0 || mem_re !== 0 || mem_we !== 0 ||
          m0_rvalid !== 0 || m1_rvalid !== 0 || m0_rdata !== '0 || m1_rdata !== '0 || stall_cnt !== '0) begin
        bad++;
        $display("FAIL reset_hold: got g=%b%b re=%b we=%b v=%b%b stall=%0d want all 0",
                 m1_gnt, m0_gnt, mem_re, mem_we, m1_rvalid, m0_rvalid, stall_cnt);
      end
    end
    rst = 1'b1;
    exp_stall = '0;
    sb.delete();
    cycle(1, 0);
    m0_req = 0;
    cycle(0, 1);
    m1_req = 0;
    cycle(0, 0);
  endtask

  task automatic test_single_read();
    apply_reset(2);
    m1_req = 1; m1_we = 0; m1_addr = 30'h10;
    cycle(0, 1);
    total++;
    if (m1_rdata !== 32'hDEADBEEF || m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_read: got d1=%h v0=%b want DEADBEEF 0", m1_rdata, m0_rvalid);
    end
    m1_req = 0;
    cycle(0, 0);
  endtask

  task automatic test_round_robin();
    apply_reset(2);
    m0_req = 1; m0_addr = 30'h11; m1_req = 1; m1_addr = 30'h12;
    for (int i = 0; i < 6; i++) cycle(i % 2 == 0, i % 2 == 1);
    total++;
    if (stall_cnt !== 16'd6) begin
      bad++;
      $display("FAIL rr_stall: got %0d want 6", stall_cnt);
    end
    m0_req = 0; m1_req = 0;
    cycle(0, 0);
  endtask

  task automatic test_lock_bound();
    apply_reset(2);
    m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 30'h30; m0_wdata = 32'hA0A0_0001;
    m1_req = 1; m1_we = 0; m1_addr = 30'h40;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0);
      m0_wdata = m0_wdata + 1;
    end
    cycle(0, 1);
    total++;
    if (stall_cnt !== 16'd6) begin
      bad++;
      $display("FAIL lock_stall: got %0d want 6", stall_cnt);
    end
    m1_req = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0);
      m0_wdata = m0_wdata + 1;
    end
    m0_req = 0; m0_lock = 0;
    cycle(0, 0);
  endtask

  task automatic test_write_read();
    apply_reset(2);
    m0_req = 1; m0_we = 1; m0_addr = 30'h20; m0_wdata = 32'h12345678;
    cycle(1, 0);
    m0_we = 0; m0_wdata = '0;
    cycle(1, 0);
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_rd: got v0=%b d0=%h want 1 12345678", m0_rvalid, m0_rdata);
    end
    m0_req = 0;
    cycle(0, 0);
  endtask

  task automatic test_reset_mid_read();
    apply_reset(2);
    m0_req = 1; m0_addr = 30'h13;
    cycle(1, 0);
    m0_req = 0;
    m1_req = 1; m1_we = 0; m1_addr = 30'h10;
    #1;
    total++;
    if (m1_gnt !== 1'b1 || mem_re !== 1'b1) begin
      bad++;
      $display("FAIL mid_gnt: got g1=%b re=%b want 1 1", m1_gnt, mem_re);
    end
    rst = 1'b0;
    m1_req = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_stall = '0;
    sb.delete();
    #1;
    total++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== '0 || stall_cnt !== '0) begin
      bad++;
      $display("FAIL mid_rvalid: got v1=%b d1=%h stall=%0d want 0 0 0", m1_rvalid, m1_rdata, stall_cnt);
    end
    m0_req = 1; m0_addr = 30'h14; m1_req = 1; m1_addr = 30'h15;
    cycle(1, 0);
    cycle(0, 1);
    m0_req = 0; m1_req = 0;
    cycle(0, 0);
  endtask

  initial begin
    exp_stall = '0;
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_bound();
    test_write_read();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous main memory (one-cycle registered read, 30-bit word address, 32-bit data) between two requesters.
- Master 0 is the CPU. Master 1 is a loader/DMA engine, e.g. a UART boot loader.
- Arbitration is round-robin, with an optional bounded lock for back-to-back bursts.
- The block tracks read ownership so each master receives only its own read data, and it keeps a saturating contention counter for the debug display.

Parameters:
- AW, 30, word-address width.
- DW, 32, data width.
- LOCK_MAX, 4, maximum consecutive locked grants while the other master is waiting (must be ≥1).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  single clock; all state changes on posedge clk.
- rst  in  1  synchronous, active-low reset.
- m0_req, m1_req  in  1  access request; held until gnt.
- m0_we, m1_we  in  1  1 = write, 0 = read; held with req.
- m0_lock, m1_lock  in  1  request to keep ownership for the next access.
- m0_addr, m1_addr  in  AW  word address; held with req.
- m0_wdata, m1_wdata  in  DW  write data; held with req.
- m0_gnt, m1_gnt  out  1  access issued to memory this cycle.
- m0_rvalid, m1_rvalid  out  1  read data valid for that master.
- m0_rdata, m1_rdata  out  DW  read data; 0 when the matching rvalid is 0.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; registered, valid the cycle after mem_re.
- stall_cnt  out  CNT_W  saturating count of cycles in which a requesting master was not granted.

Behaviour:
- Reset (rst=0 at posedge):
  - last_owner=1, so master 0 wins the first tie; lock_cnt=0; rd_owner_v=0; stall_cnt=0.
  - While rst=0: both gnt=0, mem_re=0, mem_we=0, both rvalid=0, both rdata=0.
  - A reset mid-read discards the pending rvalid; no rvalid is asserted after reset deasserts.
- Grant is combinational from req and registered state; there are no idle cycles.
  - Only one master requesting: it is granted the same cycle.
  - Both requesting, no lock in force: grant the master that is not last_owner.
  - Lock in force: the previous grant had lock=1, that master requests again, and lock_cnt<LOCK_MAX. The same master is granted again.
  - When lock_cnt reaches LOCK_MAX and the other master is requesting, ownership must pass to the other master.
  - Lock has no effect when the other master is idle. The owner is granted and lock_cnt holds at its current value.
- Issue: with gnt, mem_addr/mem_wdata come from the granted master. Set mem_we=we, mem_re=!we.
  - With no grant: mem_re=mem_we=0, and mem_addr/mem_wdata are 0.
- Registered state per posedge:
  - On any grant: last_owner ← granted index.
  - lock_cnt:
    - If the grant went to the same master as the previous grant and that grant carried lock=1: lock_cnt+1, saturating at LOCK_MAX.
    - Otherwise: lock_cnt ← 0.
  - On a read grant: rd_owner_v ← 1 and rd_owner ← granted index. Otherwise rd_owner_v ← 0.
- Read return: rvalid for rd_owner is 1 in the cycle after the read grant; rdata = mem_rdata in that cycle, else 0.
  - Back-to-back reads from alternating masters return in order, one per cycle.
  - Writes never produce rvalid.
- stall_cnt increments by 1 in any cycle where m0_req&!m0_gnt or m1_req&!m1_gnt. Both masters stalling in the same cycle still counts 1. It saturates at all-ones.
- Protocol: changing we/addr/wdata while req is high and gnt is low is illegal. The bench asserts against it; RTL behaviour in that case is unspecified.
- Address decoding is not done in this block. The caller gates req by region.

Decomposition:
- Shared package/include mem_bus_pkg:
  - AW, DW constants.
  - Master-index type: 1 bit, M_CPU=0, M_LDR=1.
  - Access-kind constants: ACC_RD=0, ACC_WR=1.
- One sub-module, rr_arb2: two-way round-robin pick with lock override.
  - Inputs: req[1:0], last_owner, lock_active.
  - Outputs: gnt[1:0].
  - Purely combinational.
- mem_arbiter holds all state (last_owner, lock_cnt, rd_owner, stall_cnt) and the datapath muxes.

Test Plan:
- Reset hold: rst=0 for 3 cycles with both req=1 → both gnt=0, mem_re=mem_we=0, rvalid=0, stall_cnt=0. The first cycle after rst=1: m0_gnt=1.
- Single master read: m1 reads addr 0x10, memory holds 0xDEADBEEF → m1_gnt the same cycle, m1_rvalid=1 and m1_rdata=0xDEADBEEF one cycle later, m0_rvalid=0.
- Contention round-robin: both masters read continuously for 6 cycles without lock → grants alternate 0,1,0,1,0,1. rvalid alternates one cycle behind. stall_cnt=6.
- Lock bound with LOCK_MAX=4: m0 writes with lock=1 continuously while m1 requests → m0 gets 5 consecutive grants (1 + 4 locked), then m1 is granted. Without a competitor, m0 is granted every cycle indefinitely.
- Write then read same address: m0 writes 0x12345678 to 0x20, then reads 0x20 → no rvalid after the write; m0_rvalid with 0x12345678 after the read.
- Reset mid-read: m1 read granted, rst=0 on the next posedge → m1_rvalid never asserts and all state returns to reset values.
